time_display_scan: RTL and testbench

- Reader side of the clock time registers: samples hour/minute/second from the time-setting/counting logic, converts each field to two decimal digits, and time-multiplexes them onto a 6-digit common-anode 7-segment display.
- Blinks the field currently being adjusted.
- Sits between the time/alarm register blocks and the board's display pins.

---
 rtl/time_display_scan.sv | 151 +++++++++++++++
 tb/tb_time_display_scan.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_scan.sv
// Scans the h/m/s snapshot onto a 6-digit common-anode 7-segment display and blinks the adjusted field.
// Optional: define LEADING_ZERO_BLANK_EN to blank the hour tens digit when hour < 10.
module time_display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [1:0] adj_sel,
    output logic [5:0] an_n,
    output logic [6:0] seg_n
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [SW-1:0] scan_cnt_reg;
    logic [2:0]    idx_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_ph_reg;
    logic [4:0]    snap_h_reg;
    logic [5:0]    snap_m_reg;
    logic [5:0]    snap_s_reg;
    logic [5:0]    an_n_reg, an_n_next;
    logic [6:0]    seg_n_reg, seg_n_next;

    logic          scan_last;
    logic          blink_last;
    logic [5:0]    field_val [3];
    logic [5:0]    field_tens [3];
    logic [5:0]    field_ones [3];
    logic          field_bad [3];
    logic [1:0]    fsel;
    logic [5:0]    digit;
    logic          dash;
    logic          blink_blank;
    logic          lz_blank;

    assign scan_last  = (scan_cnt_reg == SW'(SCAN_DIV - 1));
    assign blink_last = (blink_cnt_reg == BW'(BLINK_DIV - 1));

    assign field_val[0] = snap_s_reg;
    assign field_val[1] = snap_m_reg;
    assign field_val[2] = {1'b0, snap_h_reg};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_conv
            assign field_tens[gi] = field_val[gi] / 6'd10;
            assign field_ones[gi] = field_val[gi] % 6'd10;
            assign field_bad[gi]  = field_val[gi] > ((gi == 2) ? 6'd23 : 6'd59);
        end
    endgenerate

    function automatic logic [6:0] font(input logic [5:0] d);
        case (d)
            6'd0:    font = 7'b1000000;
            6'd1:    font = 7'b1111001;
            6'd2:    font = 7'b0100100;
            6'd3:    font = 7'b0110000;
            6'd4:    font = 7'b0011001;
            6'd5:    font = 7'b0010010;
            6'd6:    font = 7'b0000010;
            6'd7:    font = 7'b1111000;
            6'd8:    font = 7'b0000000;
            6'd9:    font = 7'b0010000;
            default: font = SEG_DASH;
        endcase
    endfunction

    // Digit pairs map to fields: idx[2:1] selects second/minute/hour, idx[0] selects tens.
    assign fsel = idx_reg[2:1];

    always_comb begin
        digit = 6'd0;
        dash  = 1'b0;
        case (fsel)
            2'd0: begin
                digit = idx_reg[0] ? field_tens[0] : field_ones[0];
                dash  = field_bad[0];
            end
            2'd1: begin
                digit = idx_reg[0] ? field_tens[1] : field_ones[1];
                dash  = field_bad[1];
            end
            default: begin
                digit = idx_reg[0] ? field_tens[2] : field_ones[2];
                dash  = field_bad[2];
            end
        endcase
    end

    // adj_sel 01/10/11 name hour/minute/second, i.e. fsel 2/1/0.
    assign blink_blank = blink_ph_reg && (adj_sel != 2'd0) && ((2'd3 - adj_sel) == fsel);

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank = (idx_reg == 3'd5) && (snap_h_reg < 5'd10);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_n_next  = 6'h3F;
        seg_n_next = 7'h7F;
        if (en) begin
            seg_n_next = dash ? SEG_DASH : font(digit);
            if ((scan_cnt_reg != '0) && !blink_blank && !lz_blank) begin
                an_n_next = ~(6'd1 << idx_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_reg  <= '0;
            idx_reg       <= 3'd0;
            blink_cnt_reg <= '0;
            blink_ph_reg  <= 1'b0;
            snap_h_reg    <= 5'd0;
            snap_m_reg    <= 6'd0;
            snap_s_reg    <= 6'd0;
            an_n_reg      <= 6'h3F;
            seg_n_reg     <= 7'h7F;
        end else begin
            scan_cnt_reg <= scan_last ? '0 : scan_cnt_reg + SW'(1);
            if (scan_last) begin
                idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
            end
            // Capture on the same edge idx wraps, so the whole next frame sees one snapshot.
            if (scan_last && idx_reg == 3'd5) begin
                snap_h_reg <= hour;
                snap_m_reg <= minute;
                snap_s_reg <= second;
            end
            if (blink_last) begin
                blink_cnt_reg <= '0;
                blink_ph_reg  <= ~blink_ph_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
            an_n_reg  <= an_n_next;
            seg_n_reg <= seg_n_next;
        end
    end

    assign an_n  = an_n_reg;
    assign seg_n = seg_n_reg;
endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: a cycle model pushes expected outputs, tasks pop and compare.
module tb_time_display_scan;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] adj_sel;
    logic [5:0] an_n;
    logic [6:0] seg_n;

    int vectors = 0;
    int miscompares = 0;

    logic [5:0] q_an [$];
    logic [6:0] q_seg [$];
    logic [5:0] ea;
    logic [6:0] es;

    // model state (value before the most recent edge is kept in e_*)
    int m_scan, m_idx, m_bcnt, m_bph, m_h, m_m, m_s;
    int e_idx, e_scan, e_bph;

    time_display_scan #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hour(hour), .minute(minute),
        .second(second), .adj_sel(adj_sel), .an_n(an_n), .seg_n(seg_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] font_f(input int d);
        case (d)
            0: font_f = 7'b1000000;
            1: font_f = 7'b1111001;
            2: font_f = 7'b0100100;
            3: font_f = 7'b0110000;
            4: font_f = 7'b0011001;
            5: font_f = 7'b0010010;
            6: font_f = 7'b0000010;
            7: font_f = 7'b1111000;
            8: font_f = 7'b0000000;
            default: font_f = 7'b0010000;
        endcase
    endfunction

    task automatic tick();
        int v, d;
        bit dsh, blank;
        logic [5:0] xa;
        logic [6:0] xs;
        xa = 6'h3F;
        xs = 7'h7F;
        if (rst_n && en) begin
            if (m_idx <= 1) v = m_s;
            else if (m_idx <= 3) v = m_m;
            else v = m_h;
            dsh = (m_idx >= 4) ? (m_h > 23) : (v > 59);
            d = (m_idx % 2 == 1) ? v / 10 : v % 10;
            xs = dsh ? 7'b0111111 : font_f(d);
            blank = (m_scan == 0);
            if (m_bph == 1 && ((adj_sel == 2'd1 && m_idx >= 4) ||
                               (adj_sel == 2'd2 && (m_idx == 2 || m_idx == 3)) ||
                               (adj_sel == 2'd3 && m_idx <= 1))) blank = 1;
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx == 5 && m_h < 10) blank = 1;
`endif
            if (!blank) xa = ~(6'd1 << m_idx);
        end
        q_an.push_back(xa);
        q_seg.push_back(xs);
        e_idx = m_idx; e_scan = m_scan; e_bph = m_bph;
        @(posedge clk);
        if (!rst_n) begin
            m_scan = 0; m_idx = 0; m_bcnt = 0; m_bph = 0; m_h = 0; m_m = 0; m_s = 0;
        end else begin
            if (m_idx == 5 && m_scan == 3) begin
                m_h = int'(hour); m_m = int'(minute); m_s = int'(second);
            end
            if (m_scan == 3) begin
                m_scan = 0;
                m_idx = (m_idx == 5) ? 0 : m_idx + 1;
            end else m_scan++;
            if (m_bcnt == 63) begin
                m_bcnt = 0; m_bph = 1 - m_bph;
            end else m_bcnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ea = q_an.pop_front(); es = q_seg.pop_front();
            vectors++;
            if (an_n !== 6'h3F || seg_n !== 7'h7F || an_n !== ea || seg_n !== es) begin
                miscompares++;
                $display("FAIL reset an_n=%h seg_n=%b required an_n=3f seg_n=1111111", an_n, seg_n);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_frames();
        logic [6:0] want [6];
        want[0] = 7'b0000010; want[1] = 7'b0010010; want[2] = 7'b0011001;
        want[3] = 7'b0110000; want[4] = 7'b0100100; want[5] = 7'b1111001;
        rst_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            ea = q_an.pop_front(); es = q_seg.pop_front();
            vectors++;
            if (an_n !== ea || seg_n !== es) begin
                miscompares++;
                $display("FAIL frames an_n=%h seg_n=%b required an_n=%h seg_n=%b", an_n, seg_n, ea, es);
            end
            vectors++;
            if (i < 24 && seg_n !== 7'b1000000) begin
                miscompares++;
                $display("FAIL first_frame_zero idx=%0d seg_n=%b required 1000000", e_idx, seg_n);
            end else if (i >= 24 && seg_n !== want[e_idx]) begin
                miscompares++;
                $display("FAIL second_frame idx=%0d seg_n=%b required %b", e_idx, seg_n, want[e_idx]);
            end
            if (e_scan == 0 || (e_idx == 5 && i < 24)) continue;
`ifdef LEADING_ZERO_BLANK_EN
            if (e_idx == 5) continue;
`endif
            vectors++;
            if (an_n !== ~(6'd1 << e_idx)) begin
                miscompares++;
                $display("FAIL slot_anode idx=%0d scan=%0d an_n=%h required %h", e_idx, e_scan, an_n, ~(6'd1 << e_idx));
            end
        end
        $display("test_frames done");
    endtask

    task automatic test_no_tearing();
        for (int i = 0; i < 48; i++) begin
            if (i == 9) second = 6'd57;
            tick();
            ea = q_an.pop_front(); es = q_seg.pop_front();
            vectors++;
            if (an_n !== ea || seg_n !== es) begin
                miscompares++;
                $display("FAIL tearing an_n=%h seg_n=%b required an_n=%h seg_n=%b", an_n, seg_n, ea, es);
            end
            if (e_idx == 0 && i >= 24) begin
                vectors++;
                if (seg_n !== 7'b1111000) begin
                    miscompares++;
                    $display("FAIL next_frame_sec seg_n=%b required 1111000", seg_n);
                end
            end
        end
        $display("test_no_tearing done");
    endtask

    task automatic test_blink();
        adj_sel = 2'b10;
        for (int i = 0; i < 192; i++) begin
            if (i == 128) adj_sel = 2'b00;
            tick();
            ea = q_an.pop_front(); es = q_seg.pop_front();
            vectors++;
            if (an_n !== ea || seg_n !== es) begin
                miscompares++;
                $display("FAIL blink an_n=%h seg_n=%b required an_n=%h seg_n=%b", an_n, seg_n, ea, es);
            end
            if (i < 128 && e_bph == 1 && (e_idx == 2 || e_idx == 3)) begin
                vectors++;
                if (an_n !== 6'h3F) begin
                    miscompares++;
                    $display("FAIL blink_blank idx=%0d an_n=%h required 3f", e_idx, an_n);
                end
            end else if (i > 128 && e_scan != 0) begin
                vectors++;
                if (an_n !== ~(6'd1 << e_idx)) begin
                    miscompares++;
                    $display("FAIL no_blink idx=%0d an_n=%h required %h", e_idx, an_n, ~(6'd1 << e_idx));
                end
            end
        end
        $display("test_blink done");
    endtask

    task automatic test_dash();
        hour = 5'd25; minute = 6'd60;
        for (int i = 0; i < 96; i++) begin
            if (i == 48) begin hour = 5'd9; minute = 6'd34; end
            tick();
            ea = q_an.pop_front(); es = q_seg.pop_front();
            vectors++;
            if (an_n !== ea || seg_n !== es) begin
                miscompares++;
                $display("FAIL dash an_n=%h seg_n=%b required an_n=%h seg_n=%b", an_n, seg_n, ea, es);
            end
            if (i >= 24 && i < 48 && e_idx >= 2) begin
                vectors++;
                if (seg_n !== 7'b0111111) begin
                    miscompares++;
                    $display("FAIL dash_digit idx=%0d seg_n=%b required 0111111", e_idx, seg_n);
                end
            end
        end
        hour = 5'd12;
        $display("test_dash done");
    endtask

    task automatic test_enable();
        for (int i = 0; i < 40; i++) begin
            if (i == 6) en = 1'b0;
            if (i == 16) en = 1'b1;
            tick();
            ea = q_an.pop_front(); es = q_seg.pop_front();
            vectors++;
            if (an_n !== ea || seg_n !== es) begin
                miscompares++;
                $display("FAIL enable an_n=%h seg_n=%b required an_n=%h seg_n=%b", an_n, seg_n, ea, es);
            end
            if (i >= 6 && i < 16) begin
                vectors++;
                if (an_n !== 6'h3F || seg_n !== 7'h7F) begin
                    miscompares++;
                    $display("FAIL disabled an_n=%h seg_n=%b required 3f 1111111", an_n, seg_n);
                end
            end
        end
        $display("test_enable done");
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 14; i++) begin
            rst_n = (i == 10 || i == 11) ? 1'b0 : 1'b1;
            tick();
            ea = q_an.pop_front(); es = q_seg.pop_front();
            vectors++;
            if (an_n !== ea || seg_n !== es) begin
                miscompares++;
                $display("FAIL reset_mid an_n=%h seg_n=%b required an_n=%h seg_n=%b", an_n, seg_n, ea, es);
            end
            if (i == 12) begin
                vectors++;
                if (an_n !== 6'h3F || seg_n !== 7'b1000000) begin
                    miscompares++;
                    $display("FAIL restart_slot0 an_n=%h seg_n=%b required 3f 1000000", an_n, seg_n);
                end
            end else if (i == 13) begin
                vectors++;
                if (an_n !== 6'h3E) begin
                    miscompares++;
                    $display("FAIL restart_idx0 an_n=%h required 3e", an_n);
                end
            end
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; adj_sel = 2'b00;
        hour = 5'd12; minute = 6'd34; second = 6'd56;
        m_scan = 0; m_idx = 0; m_bcnt = 0; m_bph = 0; m_h = 0; m_m = 0; m_s = 0;
        @(negedge clk);
        test_reset();
        test_frames();
        test_no_tearing();
        test_blink();
        test_dash();
        test_enable();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
